// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared definitions for the 4-channel arbitrating multiplexer
// and its 1x4 demux counterpart.
//   N_CH     - number of channels (4)
//   SEL_W    - width of a channel select (2)
//   ch_sel_t - channel select type, shared with the demux select
//   rr_next  - round-robin search from the channel after `last`
package arb_mux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    typedef struct packed {
        logic    found;
        ch_sel_t idx;
    } rr_pick_t;

    // Walks the offsets from farthest to nearest so that the nearest
    // requester after `last` overwrites any earlier hit. The offset N_CH
    // wraps back to `last` itself, which therefore has the lowest priority.
    function automatic rr_pick_t rr_next(input ch_sel_t last, input logic [N_CH-1:0] req);
        rr_pick_t pick;
        ch_sel_t  cand;
        pick = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = last + ch_sel_t'(k);
            if (req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_mux_4x1_rr_arb_4.sv
// rr_arb_4: round-robin pointer register plus priority search.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - per-channel request (already masked by the caller)
//   advance    - a grant is being taken this cycle; pointer moves to gnt_idx
//   gnt        - one-hot grant, zero when nothing is requested
//   gnt_idx    - index of the granted channel (meaningful only when |gnt)
module rr_arb_4
    import arb_mux_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] gnt,
    output ch_sel_t         gnt_idx
);

    ch_sel_t  last_grant;
    rr_pick_t pick;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        gnt     = '0;
        pick    = rr_next(last_grant, req);
        gnt_idx = pick.idx;
        if (pick.found) begin
            gnt[pick.idx] = 1'b1;
        end
    end

    // Pointer starts at the last channel so channel 0 has first priority.
    // It only moves on a real transfer; idle cycles never rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before the edge.
        if (!rst_n) begin
            last_grant <= ch_sel_t'(N_CH - 1);
        end else if (advance) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/arb_mux_4x1.sv
// arb_mux_4x1: 4-to-1 round-robin arbitrating multiplexer with valid/ready
// handshakes. Merges four producer streams into one registered stream and
// tags each word with its source channel.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   in_data    - per-channel data, index = channel number
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready, one-hot or zero
//   out_data   - registered merged data
//   out_sel    - registered source channel of out_data
//   out_valid  - registered output valid
//   out_ready  - downstream ready
//   stall_cnt  - saturating count of stalled cycles (ARB_MUX_STALL_CNT_EN only)
// Optional feature macro: ARB_MUX_STALL_CNT_EN.
module arb_mux_4x1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0][WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]            in_valid,
    output logic [N_CH-1:0]            in_ready,
    output logic [WIDTH-1:0]           out_data,
    output ch_sel_t                    out_sel,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef ARB_MUX_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    logic            load;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt;
    ch_sel_t         gnt_idx;
    logic            take;

    // The output register can accept a word when empty or being drained,
    // which gives one word per cycle under continuous traffic.
    assign load = !out_valid || out_ready;
    assign req  = load ? in_valid : '0;
    assign take = |gnt;

    rr_arb_4 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready = gnt;

    // out_data/out_sel hold their last values after a drain; only out_valid
    // drops when nothing new is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (take) begin
            out_data  <= in_data[gnt_idx];
            out_sel   <= gnt_idx;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_MUX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_4x1.sv
// tb_arb_mux_4x1: directed and randomized stimulus for arb_mux_4x1, compared
// against a behavioural model of the round-robin merge kept in this file.
// Build with ARB_MUX_STALL_CNT_EN to also cover the stall counter.
module tb_arb_mux_4x1;

    localparam int WIDTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [3:0][WIDTH-1:0] in_data;
    logic [3:0]            in_valid;
    logic [3:0]            in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_sel;
    logic                  out_valid;
    logic                  out_ready;
`ifdef ARB_MUX_STALL_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    arb_mux_4x1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_MUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: last granted channel, held word, stall count.
    int               m_ptr;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_sel;
    int               m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Winner for this cycle, or -1: nothing accepted while the output is
    // full and blocked; otherwise first valid channel after the pointer.
    function automatic int model_pick(input logic [3:0] v, input logic ov,
                                      input logic rdy, input int ptr);
        if (ov && !rdy) return -1;
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 3;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
`ifdef ARB_MUX_STALL_CNT_EN
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    // One clock cycle: apply inputs, check in_ready before the edge,
    // advance the model on the edge, check registered outputs after it.
    task automatic step(input logic [3:0] v, input logic rdy, input string tag);
        int         w;
        logic [3:0] exp_rdy;
        in_valid  = v;
        out_ready = rdy;
        #1;
        w       = model_pick(v, m_valid, rdy, m_ptr);
        exp_rdy = (w < 0) ? 4'b0000 : (4'b0001 << w);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (m_valid && !rdy) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (w >= 0) begin
            m_data  = in_data[w];
            m_sel   = w;
            m_valid = 1'b1;
            m_ptr   = w;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        in_data = '0;
        do_reset("reset");

        // Single request on channel 2.
        in_data[2] = 2'b11;
        step(4'b0100, 1'b1, "single");
        check("single.data_const", 32'(out_data), 32'h3);
        check("single.sel_const",  32'(out_sel),  32'h2);

        // All four valid: strict rotation from channel 0.
        do_reset("reset2");
        for (int i = 0; i < 8; i++) begin
            in_data = 8'($urandom);
            step(4'b1111, 1'b1, "rr");
            check("rr.sel_seq", 32'(out_sel), 32'(i % 4));
        end

        // Backpressure holding a word from channel 1.
        do_reset("reset3");
        step(4'b0001, 1'b1, "bp.pre0");
        in_data = 8'($urandom);
        step(4'b0010, 1'b1, "bp.pre1");
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            step(4'b1001, 1'b0, "bp.stall");
        end
        check("bp.sel_held", 32'(out_sel), 32'h1);
`ifdef ARB_MUX_STALL_CNT_EN
        check("bp.stall5", 32'(stall_cnt), 32'd5);
`endif
        step(4'b1001, 1'b1, "bp.release");
        check("bp.next_ch3", 32'(out_sel), 32'h3);

        // Idle gap must not rotate the pointer.
        do_reset("reset4");
        step(4'b0100, 1'b1, "idle.g2");
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, "idle.gap");
        step(4'b1001, 1'b1, "idle.after");
        check("idle.ch3", 32'(out_sel), 32'h3);

        // Reset while a word is stalled.
        step(4'b0010, 1'b1, "rs.load");
        step(4'b0000, 1'b0, "rs.stall");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rs.async_valid", 32'(out_valid), 32'h0);
        check_outputs("rs.async");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 1'b1, "rs.after");
        check("rs.first_ch0", 32'(out_sel), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_data = 8'($urandom);
            step(4'($urandom), ($urandom_range(0, 9) < 7), "rand");
        end

`ifdef ARB_MUX_STALL_CNT_EN
        // Saturation of the stall counter.
        do_reset("reset5");
        step(4'b0001, 1'b1, "sat.load");
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        m_stall = 65535;
        check("sat.cnt", 32'(stall_cnt), 32'hFFFF);
        check_outputs("sat");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_4x1.md
Name: arb_mux_4x1

Overview:
- 4-to-1 round-robin arbitrating multiplexer with valid/ready handshakes on every channel; the gather-side counterpart to the 1x4 select-demux.
- Merges four producer streams into one registered output stream.
- Emits the winning source index (out_sel) with each word, so a downstream 1x4 demux can route responses back on the same 2-bit select encoding (2'b00..2'b11).

Parameters:
- WIDTH, 2, data bits per channel (>=1).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  [3:0][WIDTH-1:0]  per-channel data, index = channel number.
- in_valid  input  [3:0]  per-channel valid.
- in_ready  output  [3:0]  per-channel ready; one-hot or zero.
- out_data  output  [WIDTH-1:0]  registered merged data.
- out_sel  output  [1:0]  registered source channel of out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- stall_cnt  output  [15:0]  present only with ARB_MUX_STALL_CNT_EN.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=2'b11, so channel 0 has first priority.
- Output register accept condition: load = !out_valid || out_ready.
- Arbitration (combinational):
  - When load=1, search channels starting at (last_grant+1) mod 4, wrapping 3->0.
  - First channel with in_valid=1 wins; in_ready is asserted for that channel only.
  - When load=0 or no requester: in_ready=4'b0000.
- in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on in_valid[i] & in_ready[i] at a clock edge:
  - out_data<=in_data[i], out_sel<=i, out_valid<=1, last_grant<=i.
- Output transfer on out_valid & out_ready:
  - If no input transfers in the same cycle, out_valid<=0.
  - out_data and out_sel hold their last values, not cleared.
  - Simultaneous output drain and input load is allowed: 1 word/cycle sustained throughput.
- Stall: out_valid=1 & out_ready=0 holds out_data, out_sel and last_grant stable. No input is accepted.
- Latency: 1 cycle from input handshake to out_valid.
- last_grant updates only on an input transfer. An idle cycle does not rotate priority.
- Fairness: with all four channels continuously valid and out_ready=1, grants are 0,1,2,3,0,...; no channel waits more than 3 transfers.
- Reset mid-operation: any held word is discarded; state returns to the reset values above.
- Upstream channels must hold in_data stable while in_valid=1 and not yet accepted.

Optional Feature:
- Macro ARB_MUX_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists. It increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF; cleared to 0 by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package arb_mux_pkg:
  - localparam N_CH=4, SEL_W=2.
  - typedef logic [SEL_W-1:0] ch_sel_t; this same type is used by the demux select.
  - function rr_next(ch_sel_t last, logic [N_CH-1:0] req) returning the winning index and a found flag.
- One sub-module is natural: rr_arb_4, the pointer register plus priority search.
  - Inputs: clk, rst_n, req, advance. Outputs: gnt one-hot, gnt_idx.
  - arb_mux_4x1 adds the output register and data mux around it.

Test Plan:
- Reset then single request: in_valid=4'b0100, in_data[2]=2'b11, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=2'b11, out_sel=2'b10.
- All four valid, out_ready=1 held for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_valid continuously 1 after the first cycle.
- Backpressure: out_valid=1 with out_sel=1, out_ready=0 for 5 cycles, channels 0 and 3 valid -> in_ready=0, outputs stable. When out_ready rises, next grant is channel 3 (pointer after 1 searches 2,3). With ARB_MUX_STALL_CNT_EN, stall_cnt=5.
- Idle gap: grant channel 2, then 3 idle cycles, then in_valid=4'b1001 -> channel 3 wins (pointer did not rotate while idle).
- Reset mid-stall: rst_n low while out_valid=1 -> out_valid=0 immediately (async); after release, in_valid=4'b1111 -> channel 0 granted first.
- Stall counter saturation (macro defined): hold stall for 65540 cycles -> stall_cnt=16'hFFFF.
